// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: clips plot requests, queues them and writes the framebuffer; full-screen clear sequencer.
// Optional PLOT_CLIP_COUNT_EN adds a saturating clip_count output.
module pixel_plot_sink #(
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        overflow,
  output logic        clear_done,
`ifdef PLOT_CLIP_COUNT_EN
  output logic [15:0] clip_count,
`endif
  output logic        idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [14:0] LAST = 15'(SCREEN_W * SCREEN_H - 1);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [14:0] caddr_q, caddr_d, push_addr;
  logic [2:0] ccol_q, ccol_d;
  logic pend_q, pend_d, ovf_q, ovf_d, done_q, done_d;
  logic in_range, push, pop, clear_last;
  always_comb begin
    in_range = (32'(vga_x) < SCREEN_W) && (32'(vga_y) < SCREEN_H);
    push_addr = 15'(32'(vga_y) * SCREEN_W + 32'(vga_x));
    pop = (state_q == WRITE) && fb_ready;
    push = vga_plot && in_range && ((cnt_q < DEPTH_C) || pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    clear_last = (state_q == CLEAR) && fb_ready && (caddr_q == LAST);
    // a clear_start while one is pending or running only retargets the colour
    pend_d = (clear_start && !pend_q) || (pend_q && !clear_last);
    ccol_d = clear_start ? clear_colour : ccol_q;
    ovf_d = (vga_plot && in_range && !push) || (ovf_q && !clear_start);
    done_d = clear_last;
    caddr_d = ((state_q == CLEAR) && fb_ready) ? (clear_last ? 15'd0 : caddr_q + 15'd1) : caddr_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (pend_d && cnt_q == 0) ? CLEAR : (cnt_d != 0) ? WRITE : IDLE;
      WRITE:   state_d = !fb_ready ? WRITE : (cnt_d != 0 && !pend_d) ? WRITE : IDLE;
      CLEAR:   state_d = clear_last ? IDLE : CLEAR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem[wr_q] <= {push_addr, vga_colour};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      caddr_q <= '0;
      ccol_q <= '0;
      pend_q <= 1'b0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      caddr_q <= caddr_d;
      ccol_q <= ccol_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
`ifdef PLOT_CLIP_COUNT_EN
  logic [15:0] clip_q, clip_d;
  logic clip_hit;
  always_comb begin
    clip_hit = vga_plot && !in_range;
    clip_d = clear_start ? 16'(clip_hit) : (clip_hit && clip_q != 16'hFFFF) ? clip_q + 16'd1 : clip_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clip_q <= '0;
    else clip_q <= clip_d;
  end
  assign clip_count = clip_q;
`endif
  assign fb_we = state_q != IDLE;
  assign fb_addr = (state_q == WRITE) ? mem[rd_q][17:3] : (state_q == CLEAR) ? caddr_q : 15'd0;
  assign fb_data = (state_q == WRITE) ? mem[rd_q][2:0] : (state_q == CLEAR) ? ccol_q : 3'd0;
  assign overflow = ovf_q;
  assign clear_done = done_q;
  assign idle = (state_q == IDLE) && (cnt_q == 0) && !pend_q;
endmodule

// File: tb/tb_pixel_plot_sink.sv
// tb_pixel_plot_sink: expected-write scoreboard built from plot/clear rules, checked on every accepted write.
module tb_pixel_plot_sink;
  logic clk = 0, rst = 1;
  logic [7:0] vga_x = 0;
  logic [6:0] vga_y = 0;
  logic [2:0] vga_colour = 0, clear_colour = 0, fb_data;
  logic vga_plot = 0, clear_start = 0, fb_ready = 1;
  logic [14:0] fb_addr;
  logic fb_we, overflow, clear_done, idle;
`ifdef PLOT_CLIP_COUNT_EN
  logic [15:0] clip_count;
`endif
  pixel_plot_sink dut (
    .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .clear_start(clear_start), .clear_colour(clear_colour),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
    .overflow(overflow), .clear_done(clear_done),
`ifdef PLOT_CLIP_COUNT_EN
    .clip_count(clip_count),
`endif
    .idle(idle)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [14:0] a; logic [2:0] d; logic clr; logic last;} ent_t;
  ent_t exq[$];
  int checks = 0, errors = 0, occ = 0, px_writes = 0, cyc = 0, done_cyc = -1, w805_cyc = -1;
  logic [14:0] last_px = 0, pa = 0;
  logic [2:0] pd = 0;
  bit exp_done = 0, hold_chk = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (!rst) begin
      if (hold_chk) begin
        chk("hold_we", 32'(fb_we), 1);
        chk("hold_addr", 32'(fb_addr), 32'(pa));
        chk("hold_data", 32'(fb_data), 32'(pd));
      end
      hold_chk = fb_we && !fb_ready;
      pa = fb_addr;
      pd = fb_data;
      chk("clear_done", 32'(clear_done), 32'(exp_done));
      exp_done = 0;
      if (clear_done) done_cyc = cyc;
      if (fb_we && fb_ready) begin
        if (exq.size() == 0) chk("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
        else begin
          e = exq.pop_front();
          chk("wr_addr", 32'(fb_addr), 32'(e.a));
          chk("wr_data", 32'(fb_data), 32'(e.d));
          if (!e.clr) begin
            occ--;
            px_writes++;
            last_px = fb_addr;
            if (fb_addr == 15'd805) w805_cyc = cyc;
          end
          if (e.last) exp_done = 1;
        end
      end
    end
  end
  task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    vga_x = x; vga_y = y; vga_colour = c; vga_plot = 1;
    if (int'(x) < 160 && int'(y) < 120 && occ < 8) begin
      exq.push_back('{a: 15'(int'(y) * 160 + int'(x)), d: c, clr: 1'b0, last: 1'b0});
      occ++;
    end
    @(posedge clk); #1;
    vga_plot = 0;
  endtask
  task automatic clear(input logic [2:0] c);
    clear_start = 1; clear_colour = c;
    for (int a = 0; a < 19200; a++) exq.push_back('{a: 15'(a), d: c, clr: 1'b1, last: (a == 19199)});
    @(posedge clk); #1;
    clear_start = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    exq.delete(); occ = 0; exp_done = 0; hold_chk = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int p0;
    bit found;
    #1;
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_addr", 32'(fb_addr), 0);
    chk("rst_data", 32'(fb_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_done", 32'(clear_done), 0);
    chk("rst_idle", 32'(idle), 1);
    do_reset();
    // single plot: written the next cycle, idle again after
    plot(8'd80, 7'd60, 3'b010);
    @(negedge clk);
    chk("single_we", 32'(fb_we), 1);
    chk("single_addr", 32'(fb_addr), 9680);
    chk("single_data", 32'(fb_data), 2);
    @(negedge clk);
    chk("single_we_off", 32'(fb_we), 0);
    chk("single_idle", 32'(idle), 1);
    // clipping
    do_reset();
    p0 = px_writes;
    plot(8'd160, 7'd0, 3'd1);
    plot(8'd0, 7'd120, 3'd1);
    plot(8'd159, 7'd119, 3'd5);
    repeat (5) @(negedge clk);
    chk("clip_writes", 32'(px_writes - p0), 1);
    chk("clip_addr", 32'(last_px), 19199);
`ifdef PLOT_CLIP_COUNT_EN
    chk("clip_count", 32'(clip_count), 2);
`endif
    // backpressure and overflow
    do_reset();
    fb_ready = 0;
    p0 = px_writes;
    for (int i = 0; i < 10; i++) plot(8'(i + 10), 7'd3, 3'(i));
    repeat (3) @(negedge clk);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_head_addr", 32'(fb_addr), 490);
    chk("ovf_head_data", 32'(fb_data), 0);
    @(posedge clk); #1 fb_ready = 1;
    repeat (12) @(negedge clk);
    chk("ovf_writes", 32'(px_writes - p0), 8);
    chk("ovf_last_addr", 32'(last_px), 497);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_idle", 32'(idle), 1);
    // full clear with a plot queued mid-clear and a short stall
    clear(3'b111);
    repeat (1000) @(posedge clk);
    #1;
    plot(8'd5, 7'd5, 3'd4);
    fb_ready = 0;
    repeat (3) @(posedge clk);
    #1 fb_ready = 1;
    found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      found = clear_done;
    end
    chk("clear_done_seen", 32'(found), 1);
    chk("clear_ovf_cleared", 32'(overflow), 0);
    repeat (5) @(negedge clk);
    chk("plot_after_clear", 32'(w805_cyc > done_cyc), 1);
    chk("clear_idle", 32'(idle), 1);
    // reset in the middle of a clear
    @(posedge clk); #1;
    clear(3'b011);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = fb_we && fb_addr == 15'd100;
    end
    chk("clear_reach_100", 32'(found), 1);
    rst = 1;
    #1;
    chk("midrst_we", 32'(fb_we), 0);
    chk("midrst_idle", 32'(idle), 1);
    exq.delete(); occ = 0; exp_done = 0; hold_chk = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (50) @(negedge clk);
    chk("midrst_idle_after", 32'(idle), 1);
    chk("queue_empty", 32'(exq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
